// File: rtl/nn_pkg.sv
// Shared state encoding and sizing helpers for the sequential FC neuron datapath.
package nn_pkg;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        HOLD
    } fc_state_e;

    // Sized so a full vector of extreme products plus one extra bit cannot overflow.
    function automatic int acc_width(input int width, input int ww, input int in);
        return width + ww + $clog2(in) + 1;
    endfunction

endpackage

// File: rtl/mac_lanes.sv
// LANES parallel unsigned-by-signed multipliers with a registered product stage,
// presenting the sign-extended sum of the registered lane products.
module mac_lanes #(
    parameter int WIDTH = 8,
    parameter int WW    = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [LANES*WIDTH-1:0] x,
    input  logic [LANES*WW-1:0]    w,
    output logic [ACC_W-1:0]       sum
);

    localparam int PROD_W = WIDTH + WW;

    logic [PROD_W-1:0] prod_d [LANES];
    logic [PROD_W-1:0] prod_q [LANES];

    // Activation zero-extended, weight sign-extended; the PROD_W-bit product is exact.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = {{WW{1'b0}}, x[i*WIDTH +: WIDTH]}
                      * {{WIDTH{w[i*WW+WW-1]}}, w[i*WW +: WW]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
    end

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed single-output FC neuron: streams LANES-wide beats, accumulates
// through a two-stage pipeline, adds a per-vector bias and optionally applies ReLU.
module fc_neuron_seq
    import nn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WW    = 8,
    parameter int IN    = 128,
    parameter int LANES = 4,
    parameter int RELU  = 1,
    localparam int BEATS = IN / LANES,
    localparam int ACC_W = acc_width(WIDTH, WW, IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*WIDTH-1:0] s_x,
    input  logic [LANES*WW-1:0]    s_w,
    input  logic                   s_last,
    input  logic [ACC_W-1:0]       bias,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ACC_W-1:0]       m_z,
    output logic                   err
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    fc_state_e        state_q, state_d;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept, is_last;
    logic             v1, first_q, last_q, acc_done;
    logic [ACC_W-1:0] bias_q, acc, lane_sum;

    assign s_ready = (state_q == ACC);
    assign accept  = s_valid && s_ready;
    assign is_last = (beat_cnt == CNT_W'(BEATS - 1));

    mac_lanes #(
        .WIDTH (WIDTH),
        .WW    (WW),
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .x     (s_x),
        .w     (s_w),
        .sum   (lane_sum)
    );

    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample pre-edge values; blocking here would chain stages in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACC;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:     if (accept && is_last) state_d = DRAIN;
            DRAIN:   if (acc_done)          state_d = HOLD;
            HOLD:    if (m_valid && m_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Stage 1: beat counting, first/last tagging, bias capture and framing check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            v1       <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            bias_q   <= '0;
            err      <= 1'b0;
        end else begin
            v1     <= accept;
            last_q <= accept && is_last;
            if (accept) begin
                beat_cnt <= is_last ? '0 : beat_cnt + CNT_W'(1);
                first_q  <= (beat_cnt == '0);
                if (beat_cnt == '0) bias_q <= bias;
                if (s_last != is_last) err <= 1'b1;
            end
        end
    end

    // Stage 2 accumulates; the output stage publishes once the last beat lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            acc_done <= 1'b0;
            m_valid  <= 1'b0;
            m_z      <= '0;
        end else begin
            acc_done <= v1 && last_q;
            if (v1) acc <= (first_q ? bias_q : acc) + lane_sum;
            if (acc_done) begin
                m_z     <= (RELU != 0 && acc[ACC_W-1]) ? '0 : acc;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Self-checking bench for fc_neuron_seq: RELU=1 and RELU=0 instances share stimulus;
// directed table vectors, multi-cycle corner sequences and a randomized model check.
module tb_fc_neuron_seq;

    localparam int WIDTH = 8;
    localparam int WW    = 8;
    localparam int IN    = 8;
    localparam int LANES = 4;
    localparam int ACC_W = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_last  = 1'b0;
    logic m_ready = 1'b1;
    logic [LANES*WIDTH-1:0] s_x  = '0;
    logic [LANES*WW-1:0]    s_w  = '0;
    logic [ACC_W-1:0]       bias = '0;

    logic             s_ready, m_valid, err;
    logic             s_ready0, m_valid0, err0;
    logic [ACC_W-1:0] m_z, m_z0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fc_neuron_seq #(.WIDTH(WIDTH), .WW(WW), .IN(IN), .LANES(LANES), .RELU(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_w(s_w), .s_last(s_last), .bias(bias),
        .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .err(err)
    );

    fc_neuron_seq #(.WIDTH(WIDTH), .WW(WW), .IN(IN), .LANES(LANES), .RELU(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0),
        .s_x(s_x), .s_w(s_w), .s_last(s_last), .bias(bias),
        .m_valid(m_valid0), .m_ready(m_ready), .m_z(m_z0), .err(err0)
    );

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  w;
        logic [19:0] b;
        logic [19:0] exp1;
        logic [19:0] exp0;
    } tv_t;

    tv_t tbl [8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference: dot product over all IN pairs plus bias, then optional clamp.
    function automatic logic [19:0] model(input logic [63:0] xs, input logic [63:0] ws,
                                          input logic [19:0] b, input bit relu);
        longint s;
        s = longint'($signed(b));
        for (int i = 0; i < IN; i++)
            s += longint'(xs[i*8 +: 8]) * longint'($signed(ws[i*8 +: 8]));
        if (relu && s < 0) s = 0;
        return s[19:0];
    endfunction

    task automatic send_beat(input logic [31:0] x, input logic [31:0] w, input logic last,
                             input logic [19:0] b, input bit bubbles);
        bit taken = 1'b0;
        int guard = 0;
        if (bubbles)
            for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        s_valid = 1'b1; s_x = x; s_w = w; s_last = last; bias = b;
        while (!taken && guard < 50) begin
            taken = s_ready;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!taken) check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Bias on the second beat is inverted so a resample would corrupt the result.
    task automatic drive_vec(input logic [63:0] xs, input logic [63:0] ws, input logic [19:0] b,
                             input logic [1:0] mask, input bit bubbles);
        send_beat(xs[31:0],  ws[31:0],  mask[0], b,  bubbles);
        send_beat(xs[63:32], ws[63:32], mask[1], ~b, bubbles);
    endtask

    task automatic get_result(output logic [19:0] z1, output logic [19:0] z0, output int edges);
        edges = 0;
        while (!m_valid && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!m_valid) check("result_timeout", 64'd0, 64'd1);
        z1 = m_z;
        z0 = m_z0;
    endtask

    task automatic finish_vec();
        m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input string name, input logic [63:0] xs, input logic [63:0] ws,
                           input logic [19:0] b, input logic [1:0] mask, input bit bubbles,
                           input logic [19:0] exp1, input logic [19:0] exp0);
        logic [19:0] z1, z0;
        int edges;
        drive_vec(xs, ws, b, mask, bubbles);
        get_result(z1, z0, edges);
        check({name, "_relu1"}, 64'(z1), 64'(exp1));
        check({name, "_relu0"}, 64'(z0), 64'(exp0));
        finish_vec();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] xs, ws;
        logic [19:0] b, z1, z0;
        int edges;

        tbl[0] = '{8'd1,   8'd1,   20'h00000, 20'h00008, 20'h00008};
        tbl[1] = '{8'd255, 8'h80,  20'h00000, 20'h00000, 20'hC0400};
        tbl[2] = '{8'd1,   8'd1,   20'hFFFF6, 20'h00000, 20'hFFFFE};
        tbl[3] = '{8'd1,   8'd1,   20'h00005, 20'h0000D, 20'h0000D};
        tbl[4] = '{8'd2,   8'd3,   20'h00000, 20'h00030, 20'h00030};
        tbl[5] = '{8'd255, 8'd127, 20'h00000, 20'h3F408, 20'h3F408};
        tbl[6] = '{8'd1,   8'hFF,  20'h00003, 20'h00000, 20'hFFFFB};
        tbl[7] = '{8'd0,   8'h80,  20'h7FFFF, 20'h7FFFF, 20'h7FFFF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready",  64'(s_ready),  64'd1);
        check("rst_m_valid",  64'(m_valid),  64'd0);
        check("rst_m_z",      64'(m_z),      64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_s_ready0", 64'(s_ready0), 64'd1);
        check("rst_m_valid0", 64'(m_valid0), 64'd0);
        check("rst_err0",     64'(err0),     64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency and drain behaviour on the simplest vector
        drive_vec({8{8'd1}}, {8{8'd1}}, 20'd0, 2'b10, 1'b0);
        check("drain_s_ready", 64'(s_ready), 64'd0);
        get_result(z1, z0, edges);
        check("latency_edges", 64'(edges), 64'd2);
        check("ones_z", 64'(z1), 64'd8);
        check("ones_err", 64'(err), 64'd0);
        finish_vec();

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("tbl%0d", i), {8{tbl[i].x}}, {8{tbl[i].w}}, tbl[i].b,
                    2'b10, 1'b0, tbl[i].exp1, tbl[i].exp0);

        // Backpressure: result held stable, input side blocked until handshake
        m_ready = 1'b0;
        drive_vec({8{8'd3}}, {8{8'd5}}, 20'd0, 2'b10, 1'b0);
        get_result(z1, z0, edges);
        check("bp_first_z", 64'(z1), 64'd120);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_valid%0d", k), 64'(m_valid), 64'd1);
            check($sformatf("bp_hold_z%0d", k),     64'(m_z),     64'd120);
            check($sformatf("bp_hold_ready%0d", k), 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_s_ready", 64'(s_ready), 64'd1);
        check("bp_after_m_valid", 64'(m_valid), 64'd0);
        run_vec("b2b", {8{8'd4}}, {8{8'hFE}}, 20'd7, 2'b10, 1'b0, 20'h00000, 20'hFFFC7);

        // Early s_last: err sets and sticks, sums unaffected
        run_vec("early_last", {8{8'd1}}, {8{8'd2}}, 20'd0, 2'b11, 1'b0, 20'h00010, 20'h00010);
        check("early_last_err", 64'(err), 64'd1);
        run_vec("sticky", {8{8'd1}}, {8{8'd1}}, 20'd0, 2'b10, 1'b0, 20'h00008, 20'h00008);
        check("sticky_err", 64'(err), 64'd1);

        // Reset mid-vector discards the partial beat
        send_beat({4{8'd9}}, {4{8'd9}}, 1'b0, 20'd100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_err",     64'(err),     64'd0);
        check("midrst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec("after_rst", {8{8'd2}}, {8{8'd3}}, 20'd0, 2'b10, 1'b0, 20'h00030, 20'h00030);
        check("after_rst_err", 64'(err), 64'd0);

        // Missing s_last on the final beat also flags a framing error
        run_vec("missing_last", {8{8'd1}}, {8{8'd1}}, 20'd0, 2'b00, 1'b0, 20'h00008, 20'h00008);
        check("missing_last_err", 64'(err), 64'd1);
        do_reset();

        // Randomized vectors with input bubbles
        for (int n = 0; n < 200; n++) begin
            xs = {$urandom(), $urandom()};
            ws = {$urandom(), $urandom()};
            b  = 20'($signed(18'($urandom())));
            run_vec($sformatf("rand%0d", n), xs, ws, b, 2'b10, 1'b1,
                    model(xs, ws, b, 1'b1), model(xs, ws, b, 1'b0));
        end
        check("rand_err", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
